// File: rtl/intdiv_mulacc.sv
// Sequential signed multiply-accumulate p = q*y + r using radix-2 Booth recoding,
// one recoded digit per cycle, with valid/ready handshakes on both sides.
module intdiv_mulacc #(
  parameter int N = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   q,
  input  logic signed [N-1:0]   y,
  input  logic signed [N-1:0]   r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N-1:0] p
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [N:0]     a_q, a_d;
  logic [N-1:0]          qr_q, qr_d;
  logic                  qm1_q, qm1_d;
  logic signed [N:0]     yr_q, yr_d;
  logic signed [N-1:0]   rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [2*N-1:0] p_q, p_d;
  logic signed [N:0]     sum;

  // Booth digit {Qr[0], q_m1}: 01 -> +y, 10 -> -y, else 0
  function automatic logic signed [N:0] booth_add(input logic signed [N:0] acc,
                                                  input logic signed [N:0] yv,
                                                  input logic [1:0]        pair);
    case (pair)
      2'b01:   return acc + yv;
      2'b10:   return acc - yv;
      default: return acc;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    yr_d    = yr_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sum     = booth_add(a_q, yr_q, {qr_q[0], qm1_q});
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = '0;
          qr_d    = q;
          qm1_d   = 1'b0;
          yr_d    = {y[N-1], y};
          rr_d    = r;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // arithmetic shift of {A, Qr, q_m1} after the add/subtract
        a_d   = {sum[N], sum[N:1]};
        qr_d  = {sum[0], qr_q[N-1:1]};
        qm1_d = qr_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          p_d     = {a_d[N-1:0], qr_d} + {{N{rr_q[N-1]}}, rr_q};
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      yr_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      yr_q    <= yr_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule
